// File: rtl/sdr_16_rd_capture_if.sv
// Read-capture bus between the SDRAM control/IO side and the egress FIFO.
interface sdr_16_rd_capture_if #(
  parameter int unsigned pend_w = 3
);
  logic              cmd_read;
  logic [15:0]       dq_i;
  logic              fifo_full;
  logic              clr_err;
  logic              fifo_wr;
  logic [31:0]       fifo_wr_data;
  logic [pend_w-1:0] rd_pending;
  logic              rd_idle;
  logic              err_overrun;
  logic              err_proto;

  modport master (
    output cmd_read, dq_i, fifo_full, clr_err,
    input  fifo_wr, fifo_wr_data, rd_pending, rd_idle, err_overrun, err_proto
  );

  modport slave (
    input  cmd_read, dq_i, fifo_full, clr_err,
    output fifo_wr, fifo_wr_data, rd_pending, rd_idle, err_overrun, err_proto
  );
endinterface

// File: rtl/sdr_16_rd_capture.sv
// SDR SDRAM 16-bit read-data capture: times the two BL2 beats after each RD
// command, packs them into a 32-bit FIFO word, tracks outstanding reads and
// raises sticky overrun / protocol error flags.
module sdr_16_rd_capture #(
  parameter int unsigned cl     = 2,
  parameter int unsigned io_dly = 1,
  parameter int unsigned pend_w = 3
) (
  input logic               sdram_clk,
  input logic               sdram_rst,
  sdr_16_rd_capture_if.slave bus
);

  localparam int unsigned LAT = cl + io_dly;
  // The last delay stage lives in the sequencer state (tap0), so the shift
  // register itself is one stage shorter than the full latency.
  localparam int unsigned DL = LAT - 1;
  localparam logic [pend_w-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HI    = 2'b01,
    S_LO    = 2'b10,
    S_LO_HI = 2'b11
  } cap_state_t;

  cap_state_t        state, state_nxt;
  logic [DL-1:0]     dly;
  logic              cmd_prev;
  logic              cmd_acc;
  logic              proto_hit;
  logic              cap_hi, cap_lo;
  logic [15:0]       hi_reg;
  logic              fifo_wr_q;
  logic [31:0]       wr_data_q;
  logic [pend_w-1:0] pend_q, pend_nxt;
  logic              idle_q;
  logic              ovr_q, proto_q;

  assign cmd_acc   = bus.cmd_read & ~cmd_prev;
  assign proto_hit = bus.cmd_read &  cmd_prev;

  // Delay line carrying accepted RD commands toward the beat0 position.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst) begin
      dly      <= '0;
      cmd_prev <= 1'b0;
    end else begin
      dly[0]   <= cmd_acc;
      for (int unsigned i = 1; i < DL; i++) dly[i] <= dly[i-1];
      cmd_prev <= bus.cmd_read;
    end
  end

  // Sequencer state register.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Decode capture strobes from the taps; next tap1 is the current tap0 and
  // next tap0 is the delay line output.
  always_comb begin
    state_nxt = S_IDLE;
    cap_hi    = 1'b0;
    cap_lo    = 1'b0;
    case (state)
      S_HI:    cap_hi = 1'b1;
      S_LO:    cap_lo = 1'b1;
      S_LO_HI: begin
        cap_hi = 1'b1;
        cap_lo = 1'b1;
      end
      default: ;
    endcase
    case ({cap_hi, dly[DL-1]})
      2'b01:   state_nxt = S_HI;
      2'b10:   state_nxt = S_LO;
      2'b11:   state_nxt = S_LO_HI;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Beat capture and word assembly; in LO_HI the old hi_reg feeds the word
  // while the new beat0 is loaded.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst) begin
      hi_reg    <= '0;
      fifo_wr_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      fifo_wr_q <= cap_lo;
      if (cap_hi) hi_reg    <= bus.dq_i;
      if (cap_lo) wr_data_q <= {hi_reg, bus.dq_i};
    end
  end

  // Saturating outstanding-read count; never drops below zero.
  always_comb begin
    pend_nxt = pend_q;
    if (cmd_acc && !fifo_wr_q && (pend_q != PEND_MAX))
      pend_nxt = pend_q + 1'b1;
    else if (!cmd_acc && fifo_wr_q && (pend_q != '0))
      pend_nxt = pend_q - 1'b1;
  end

  // Pending counter and registered idle flag.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst) begin
      pend_q <= '0;
      idle_q <= 1'b1;
    end else begin
      pend_q <= pend_nxt;
      idle_q <= (pend_nxt == '0);
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst) begin
      ovr_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      ovr_q   <= (fifo_wr_q & bus.fifo_full) | (ovr_q   & ~bus.clr_err);
      proto_q <= proto_hit                   | (proto_q & ~bus.clr_err);
    end
  end

  assign bus.fifo_wr      = fifo_wr_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.rd_pending   = pend_q;
  assign bus.rd_idle      = idle_q;
  assign bus.err_overrun  = ovr_q;
  assign bus.err_proto    = proto_q;

endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Bench for sdr_16_rd_capture: three instances (cl/io_dly/pend_w = 2/1/3,
// 3/0/3, 3/2/2) share one stimulus stream and are compared each cycle with a
// cycle-indexed behavioural model.
module tb_sdr_16_rd_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd = 1'b0;
  logic [15:0] dq = '0;
  logic        full = 1'b0;
  logic        clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdr_16_rd_capture_if #(.pend_w(3)) if_a ();
  sdr_16_rd_capture_if #(.pend_w(3)) if_b ();
  sdr_16_rd_capture_if #(.pend_w(2)) if_c ();

  assign if_a.cmd_read = cmd;  assign if_a.dq_i = dq;  assign if_a.fifo_full = full;  assign if_a.clr_err = clr;
  assign if_b.cmd_read = cmd;  assign if_b.dq_i = dq;  assign if_b.fifo_full = full;  assign if_b.clr_err = clr;
  assign if_c.cmd_read = cmd;  assign if_c.dq_i = dq;  assign if_c.fifo_full = full;  assign if_c.clr_err = clr;

  sdr_16_rd_capture #(.cl(2), .io_dly(1), .pend_w(3)) dut_a (.sdram_clk(clk), .sdram_rst(rst_n), .bus(if_a));
  sdr_16_rd_capture #(.cl(3), .io_dly(0), .pend_w(3)) dut_b (.sdram_clk(clk), .sdram_rst(rst_n), .bus(if_b));
  sdr_16_rd_capture #(.cl(3), .io_dly(2), .pend_w(2)) dut_c (.sdram_clk(clk), .sdram_rst(rst_n), .bus(if_c));

  // {fifo_wr, fifo_wr_data, rd_pending(3b), rd_idle, err_overrun, err_proto}
  logic [38:0] act [3];
  assign act[0] = {if_a.fifo_wr, if_a.fifo_wr_data, if_a.rd_pending, if_a.rd_idle, if_a.err_overrun, if_a.err_proto};
  assign act[1] = {if_b.fifo_wr, if_b.fifo_wr_data, if_b.rd_pending, if_b.rd_idle, if_b.err_overrun, if_b.err_proto};
  assign act[2] = {if_c.fifo_wr, if_c.fifo_wr_data, 1'b0, if_c.rd_pending, if_c.rd_idle, if_c.err_overrun, if_c.err_proto};

  // Reference model: history of accepted reads and DQ per cycle.
  int          lat  [3] = '{3, 3, 5};
  int          pmax [3] = '{7, 7, 3};
  bit          acc_h [0:4095];
  logic [15:0] dq_h  [0:4095];
  logic        e_wr   [3];
  logic [31:0] e_data [3];
  int          e_pend [3];
  logic        e_ov   [3];
  logic        e_pr   [3];
  logic        m_prev = 1'b0;
  int          last_rst = -1;
  int          cyc = 0;

  function automatic logic [38:0] exp_vec(int d);
    logic [2:0] p;
    p = 3'(e_pend[d]);
    return {e_wr[d], e_data[d], p, (e_pend[d] == 0), e_ov[d], e_pr[d]};
  endfunction

  // Advance one clock: update the model with this cycle's inputs, then clock.
  task automatic tick();
    bit acc_now;
    dq_h[cyc] = dq;
    if (!rst_n) begin
      acc_h[cyc] = 1'b0;
      m_prev     = 1'b0;
      last_rst   = cyc;
      for (int d = 0; d < 3; d++) begin
        e_wr[d] = 1'b0; e_data[d] = '0; e_pend[d] = 0; e_ov[d] = 1'b0; e_pr[d] = 1'b0;
      end
    end else begin
      acc_now    = cmd && !m_prev;
      acc_h[cyc] = acc_now;
      for (int d = 0; d < 3; d++) begin
        int   t;
        logic wr_now;
        t      = cyc - lat[d] - 1;
        wr_now = e_wr[d];
        if (wr_now && full) e_ov[d] = 1'b1; else if (clr) e_ov[d] = 1'b0;
        if (cmd && m_prev)  e_pr[d] = 1'b1; else if (clr) e_pr[d] = 1'b0;
        if (acc_now && !wr_now && e_pend[d] < pmax[d]) e_pend[d]++;
        else if (!acc_now && wr_now && e_pend[d] > 0)  e_pend[d]--;
        e_wr[d] = (t >= 0) && acc_h[t] && (last_rst < t);
        if (e_wr[d]) e_data[d] = {dq_h[cyc-1], dq_h[cyc]};
      end
      m_prev = cmd;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== 39'h4) begin
          errors++;
          $display("FAIL reset_state dut%0d cyc %0d: got %h expected %h", d, cyc, act[d], 39'h4);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    for (int k = 0; k < 14; k++) begin
      cmd = (k == 0);
      dq  = (k == 3) ? 16'hA5A5 : (k == 4) ? 16'h3C3C : 16'($urandom);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL single dut%0d cyc %0d: got %h expected %h", d, cyc, act[d], exp_vec(d));
        end
      end
      checks++;
      if (if_a.fifo_wr !== (k == 4) || if_b.fifo_wr !== (k == 4)) begin
        errors++;
        $display("FAIL single_wr_timing k %0d: got a=%b b=%b expected %b", k, if_a.fifo_wr, if_b.fifo_wr, (k == 4));
      end
      checks++;
      if (if_a.rd_pending !== ((k <= 4) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL single_pending k %0d: got %0d expected %0d", k, if_a.rd_pending, (k <= 4) ? 1 : 0);
      end
      if (k == 4) begin
        checks++;
        if (if_a.fifo_wr_data !== 32'hA5A53C3C) begin
          errors++;
          $display("FAIL single_data: got %h expected a5a53c3c", if_a.fifo_wr_data);
        end
      end
    end
    cmd = 1'b0;
  endtask

  task automatic test_back_to_back();
    int peak_a = 0;
    int peak_c = 0;
    for (int k = 0; k < 16; k++) begin
      cmd = (k <= 6) && (k % 2 == 0);
      dq  = (k >= 3 && k <= 10) ? 16'(k - 2) : 16'($urandom);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL back_to_back dut%0d cyc %0d: got %h expected %h", d, cyc, act[d], exp_vec(d));
        end
      end
      if (int'(if_a.rd_pending) > peak_a) peak_a = int'(if_a.rd_pending);
      if (int'(if_c.rd_pending) > peak_c) peak_c = int'(if_c.rd_pending);
      if (k == 4 || k == 6 || k == 8 || k == 10) begin
        checks++;
        if (if_a.fifo_wr !== 1'b1 || if_a.fifo_wr_data !== {16'(k - 3), 16'(k - 2)}) begin
          errors++;
          $display("FAIL b2b_word k %0d: got wr=%b data=%h expected wr=1 data=%h",
                   k, if_a.fifo_wr, if_a.fifo_wr_data, {16'(k - 3), 16'(k - 2)});
        end
      end
    end
    checks++;
    if (peak_a != 3 || peak_c != 3) begin
      errors++;
      $display("FAIL b2b_peak_pending: got a=%0d c=%0d expected 3 and 3 (saturated)", peak_a, peak_c);
    end
    cmd = 1'b0;
  endtask

  task automatic test_protocol();
    int wr_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      cmd = (k <= 1);
      clr = (k == 10);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL protocol dut%0d cyc %0d: got %h expected %h", d, cyc, act[d], exp_vec(d));
        end
      end
      if (if_a.fifo_wr === 1'b1) wr_cnt++;
      if (k >= 1) begin
        checks++;
        if (if_a.err_proto !== (k < 10)) begin
          errors++;
          $display("FAIL proto_flag k %0d: got %b expected %b", k, if_a.err_proto, (k < 10));
        end
      end
    end
    checks++;
    if (wr_cnt != 1 || if_a.rd_pending !== 3'd0) begin
      errors++;
      $display("FAIL proto_single_write: got writes=%0d pending=%0d expected 1 and 0", wr_cnt, if_a.rd_pending);
    end
    cmd = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_overrun();
    full = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cmd = (k == 0);
      clr = (k == 9);
      dq  = 16'($urandom);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL overrun dut%0d cyc %0d: got %h expected %h", d, cyc, act[d], exp_vec(d));
        end
      end
      checks++;
      if (if_a.fifo_wr !== (k == 4) || if_a.err_overrun !== (k >= 5 && k <= 8)) begin
        errors++;
        $display("FAIL overrun_flag k %0d: got wr=%b ovr=%b expected wr=%b ovr=%b",
                 k, if_a.fifo_wr, if_a.err_overrun, (k == 4), (k >= 5 && k <= 8));
      end
    end
    full = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 12; k++) begin
      cmd   = (k == 0);
      rst_n = (k != 4);
      dq    = 16'($urandom);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL reset_mid dut%0d cyc %0d: got %h expected %h", d, cyc, act[d], exp_vec(d));
        end
      end
      checks++;
      if (if_a.fifo_wr !== 1'b0 || if_a.rd_pending !== ((k < 4) ? 3'd1 : 3'd0) || if_a.rd_idle !== (k >= 4)) begin
        errors++;
        $display("FAIL reset_mid_state k %0d: got wr=%b pend=%0d idle=%b expected wr=0 pend=%0d idle=%b",
                 k, if_a.fifo_wr, if_a.rd_pending, if_a.rd_idle, (k < 4) ? 1 : 0, (k >= 4));
      end
    end
    cmd   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      cmd   = ($urandom % 3) == 0;
      dq    = 16'($urandom);
      full  = ($urandom % 4) == 0;
      clr   = ($urandom % 16) == 0;
      rst_n = ($urandom % 200) != 0;
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d: got %h expected %h", d, cyc, act[d], exp_vec(d));
        end
      end
    end
    cmd = 1'b0; full = 1'b0; clr = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_protocol();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdr_16_rd_capture.md
Name: sdr_16_rd_capture

Overview:
- Read-data return stage directly downstream of the 16-bit SDR SDRAM control FSM.
- Uses the FSM's registered cmd_read pulse (one per RD command, burst length 2) to time capture of the two 16-bit beats on the SDRAM DQ bus after CAS latency plus I/O register delay.
- Assembles the two beats into one 32-bit word and writes it into the egress (read) FIFO.
- Tracks outstanding reads and flags overrun and protocol errors.

Parameters:
cl, 2, SDRAM CAS latency in sdram_clk cycles; legal values 2 and 3; must match the LMR setting.
io_dly, 1, extra registered cycles between SDRAM pins and dq_i (IOB input flops); legal values 0 to 2.
pend_w, 3, width of the outstanding-read counter.

Ports:
sdram_clk  in  1  SDRAM-domain clock; all logic is on the rising edge.
sdram_rst  in  1  synchronous, active-low reset.
cmd_read  in  1  one-cycle pulse, high in the cycle the RD command is driven on the SDRAM cmd pins.
dq_i  in  16  registered SDRAM DQ input data.
fifo_full  in  1  egress FIFO full.
fifo_wr  out  1  egress FIFO write strobe, one cycle per assembled word.
fifo_wr_data  out  32  assembled word: first beat in [31:16], second beat in [15:0].
rd_pending  out  pend_w  count of RD commands issued but not yet written to the FIFO.
rd_idle  out  1  high when rd_pending==0.
err_overrun  out  1  sticky; set when fifo_wr fires while fifo_full is high.
err_proto  out  1  sticky; set when cmd_read is high in two consecutive cycles.
clr_err  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (sdram_rst==0 at a clock edge):
  - fifo_wr=0, fifo_wr_data=0, rd_pending=0, rd_idle=1, err_overrun=0, err_proto=0.
  - Delay line, phase logic and holding register are cleared.
  - Reset mid-burst discards the in-flight beats; no fifo_wr follows reset release.
- Latency:
  - LAT = cl+io_dly.
  - cmd_read high in cycle T: beat0 is taken from dq_i in cycle T+LAT, beat1 in cycle T+LAT+1.
  - fifo_wr=1 with the assembled fifo_wr_data in cycle T+LAT+2.
- Delay line: shift register of depth LAT, fed by the accepted cmd_read.
  - Its output tap (tap0) marks beat0.
  - tap0 delayed by one cycle (tap1) marks beat1.
- Capture pipeline:
  - tap0: hi_reg <= dq_i.
  - tap1: fifo_wr_data <= {hi_reg, dq_i}, and fifo_wr is set for exactly the next cycle.
  - fifo_wr_data holds its value until the next write.
- Back-to-back reads:
  - cmd_read every 2nd cycle (the FSM's count0 cadence) gives a continuous beat stream.
  - tap0 of read N+1 coincides with the fifo_wr of read N; both proceed, so the pipeline must not stall.
  - Sustained rate is one fifo_wr every 2 cycles.
- Protocol check:
  - cmd_read high in cycle T and T+1: the second pulse is ignored (not entered into the delay line, not counted) and err_proto is set.
- Pending counter:
  - +1 on an accepted cmd_read, -1 on fifo_wr; simultaneous events leave it unchanged.
  - Saturates at 2^pend_w-1 and does not wrap.
  - rd_idle is registered and consistent with rd_pending in the same cycle.
- Overrun:
  - fifo_wr is never withheld, because SDRAM data cannot be stalled.
  - If fifo_full==1 in the fifo_wr cycle, err_overrun is set; the FIFO drops the word.
- Error flags:
  - clr_err in the same cycle as a new error event: the set wins.
  - Flags are otherwise held until clr_err or reset.
- Capture sequencer states, derived from the taps:
  - IDLE: no tap active.
  - HI: tap0 only.
  - LO: tap1 only.
  - LO_HI: tap1 and tap0 together, during overlapping reads.
  - Any state may move to any other state according to the next tap values.
  - No other state exists.

Test Plan:
- cl=2, io_dly=1; reset released; single cmd_read at cycle 10; dq_i=16'hA5A5 at cycle 13 and 16'h3C3C at cycle 14 -> fifo_wr=1 only in cycle 15 with fifo_wr_data=32'hA5A53C3C; rd_pending 1 in cycles 11-15, 0 from cycle 16.
- cmd_read at cycles 10,12,14,16 with incrementing beats 16'h0001..16'h0008 -> fifo_wr in cycles 15,17,19,21 with data 0001_0002, 0003_0004, 0005_0006, 0007_0008; rd_pending peaks at 3; no error flags.
- cl=3, io_dly=0; cmd_read at cycle 5 -> beats taken in cycles 8 and 9, fifo_wr in cycle 10.
- cmd_read at cycles 20 and 21 -> err_proto=1 from cycle 22; exactly one fifo_wr; rd_pending returns to 0; clr_err at cycle 30 -> err_proto=0 in cycle 31.
- fifo_full=1 held; single read -> fifo_wr still pulses, err_overrun=1 the next cycle and stays high until clr_err.
- sdram_rst low for one cycle at cycle 14 during the first scenario -> no fifo_wr in cycle 15 or later; rd_pending=0 and rd_idle=1 after the reset cycle.
